// File: rtl/tinyalu_param.sv
// tinyalu_param: parametrised TinyALU with iterative shift-add multiply,
// illegal-opcode flag, operand latching and a saturating command counter.
module tinyalu_param #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-1:0]       B,
  input  logic [2:0]             op,
  input  logic                   start,
  output logic                   done,
  output logic [2*WIDTH-1:0]     result,
  output logic                   err,
  output logic [CNT_WIDTH-1:0]   cmd_count
);

  localparam int SW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    EXEC1,
    MUL,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   a_r, b_r;
  logic [2:0]         op_r;
  logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
  logic [SW-1:0]      step;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] exec_res;
  logic               exec_err;
  logic               accept, last, fin;

  assign accept  = (state_q == IDLE) && start && (op != OP_NOP);
  assign last    = (step == LAST);
  assign fin     = (state_q == EXEC1) || ((state_q == MUL) && last);
  assign acc_nxt = acc + (b_r[step] ? mcand : '0);
  assign sum     = {1'b0, a_r} + {1'b0, b_r};

  always_comb begin
    exec_res = '0;
    exec_err = 1'b0;
    unique case (op_r)
      OP_ADD:  exec_res = {{(WIDTH-1){1'b0}}, sum};
      OP_AND:  exec_res = {{WIDTH{1'b0}}, a_r & b_r};
      OP_XOR:  exec_res = {{WIDTH{1'b0}}, a_r ^ b_r};
      OP_NOP,
      OP_MUL:  exec_res = '0;
      default: exec_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && op == OP_MUL)
          state_d = MUL;
        else if (start && op != OP_NOP)
          state_d = EXEC1;
      end
      EXEC1: state_d = HOLD;
      MUL:   if (last) state_d = HOLD;
      HOLD:  if (!start) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= '0;
      acc       <= '0;
      mcand     <= '0;
      step      <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      result    <= '0;
      cmd_count <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (accept) begin
        a_r   <= A;
        b_r   <= B;
        op_r  <= op;
        acc   <= '0;
        mcand <= {{WIDTH{1'b0}}, A};
        step  <= '0;
      end
      if (state_q == MUL) begin
        acc   <= acc_nxt;
        mcand <= mcand << 1;
        step  <= step + 1'b1;
      end
      if (fin) begin
        done   <= 1'b1;
        result <= (state_q == MUL) ? acc_nxt : exec_res;
        err    <= (state_q == MUL) ? 1'b0 : exec_err;
        if (cmd_count != '1)
          cmd_count <= cmd_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tinyalu_param.sv
// tb_tinyalu_param: directed and random commands against a behavioural
// model of the ALU for WIDTH=8 and a WIDTH=16/CNT_WIDTH=2 instance.
module tb_tinyalu_param;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  a8, b8;
  logic [2:0]  op8;
  logic        start8;
  logic        done8, err8;
  logic [15:0] result8, cnt8;

  logic [15:0] a16, b16;
  logic [2:0]  op16;
  logic        start16;
  logic        done16, err16;
  logic [31:0] result16;
  logic [1:0]  cnt16;

  tinyalu_param #(.WIDTH(8), .CNT_WIDTH(16)) dut8 (
    .clk(clk), .reset_n(reset_n), .A(a8), .B(b8), .op(op8),
    .start(start8), .done(done8), .result(result8), .err(err8),
    .cmd_count(cnt8)
  );

  tinyalu_param #(.WIDTH(16), .CNT_WIDTH(2)) dut16 (
    .clk(clk), .reset_n(reset_n), .A(a16), .B(b16), .op(op16),
    .start(start16), .done(done16), .result(result16), .err(err16),
    .cmd_count(cnt16)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_cnt8 = 0;
  int m_cnt16 = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model8(input logic [2:0] o,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    int x, y;
    x = a;
    y = b;
    case (o)
      3'd1:    return 16'(x + y);
      3'd2:    return 16'(x & y);
      3'd3:    return 16'(x ^ y);
      3'd4:    return 16'(x * y);
      default: return 16'd0;
    endcase
  endfunction

  task automatic cmd8(input logic [2:0] o, input logic [7:0] a,
                      input logic [7:0] b, input int hold_extra,
                      input bit zero_inputs);
    int lat;
    bit seen;
    int exp_lat;
    exp_lat = (o == 3'd4) ? 8 : 1;
    @(negedge clk);
    op8 = o; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = zero_inputs ? 8'h00 : 8'($urandom);
    b8 = zero_inputs ? 8'h00 : 8'($urandom);
    op8 = 3'($urandom);
    lat = 0;
    seen = 0;
    while (!seen && lat < 14) begin
      @(posedge clk); #1;
      lat++;
      if (done8) seen = 1;
    end
    if (m_cnt8 < 65535) m_cnt8++;
    check("latency8", lat, exp_lat);
    check("result8", result8, model8(o, a, b));
    check("err8", err8, (o > 3'd4) ? 1 : 0);
    check("count8", cnt8, m_cnt8);
    for (int i = 0; i < hold_extra; i++) begin
      @(posedge clk); #1;
      check("hold_done8", done8, 0);
    end
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk); #1;
    check("pulse_end8", done8, 0);
    check("hold_count8", cnt8, m_cnt8);
  endtask

  task automatic nop8(input int cycles);
    @(negedge clk);
    op8 = 3'd0; a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check("nop_done8", done8, 0);
    end
    check("nop_count8", cnt8, m_cnt8);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic mul16(input logic [15:0] a, input logic [15:0] b);
    int lat;
    bit seen;
    logic [31:0] exp_r;
    exp_r = 32'(longint'(a) * longint'(b));
    @(negedge clk);
    op16 = 3'd4; a16 = a; b16 = b; start16 = 1'b1;
    @(posedge clk); #1;
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    lat = 0;
    seen = 0;
    while (!seen && lat < 24) begin
      @(posedge clk); #1;
      lat++;
      if (done16) seen = 1;
    end
    if (m_cnt16 < 3) m_cnt16++;
    check("latency16", lat, 16);
    check("result16", result16, exp_r);
    check("err16", err16, 0);
    check("count16", cnt16, m_cnt16);
    @(negedge clk);
    start16 = 1'b0;
    @(posedge clk); #1;
    check("pulse_end16", done16, 0);
  endtask

  initial begin
    a8 = '0; b8 = '0; op8 = '0; start8 = 1'b0;
    a16 = '0; b16 = '0; op16 = '0; start16 = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", done8, 0);
    check("rst_result", result8, 0);
    check("rst_err", err8, 0);
    check("rst_count", cnt8, 0);
    check("rst_count16", cnt16, 0);
    @(negedge clk);
    reset_n = 1'b1;

    cmd8(3'd1, 8'hFF, 8'h01, 0, 0);
    cmd8(3'd4, 8'hFF, 8'hFF, 0, 1);
    cmd8(3'd6, 8'h12, 8'h34, 0, 0);
    cmd8(3'd2, 8'hF0, 8'h3C, 0, 0);

    // multiply aborted by reset at k+3
    @(negedge clk);
    op8 = 3'd4; a8 = 8'h10; b8 = 8'h10; start8 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("abort_pre", done8, 0);
    end
    reset_n = 1'b0;
    start8 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("abort_done", done8, 0);
      if (i == 2) reset_n = 1'b1;
    end
    m_cnt8 = 0;
    check("abort_count", cnt8, 0);
    cmd8(3'd1, 8'd3, 8'd4, 0, 0);

    cmd8(3'd3, 8'hAA, 8'h55, 5, 0);
    nop8(4);

    for (int i = 0; i < 30; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      if (o == 3'd0)
        nop8(2);
      else
        cmd8(o, 8'($urandom), 8'($urandom), $urandom_range(0, 2), 0);
    end

    for (int i = 0; i < 4; i++)
      mul16(16'hFFFF, 16'h0002);
    mul16(16'($urandom), 16'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
